// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder
// Description : SPI-flash slave model (mode 0) that oversamples the flash
//               pins on the system clock. It serves 0x03 read, 0x9F JEDEC ID
//               and 0x05 status from a backdoor-loaded byte array.
//               Optional macro SPI_FLASH_FAST_READ_EN enables 0x0B fast read.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
  parameter int          MEM_BYTES = 4096,
  parameter int          ADDR_W    = 12,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  input  logic              i_load_we,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [7:0]        i_load_data,
  output logic              o_busy,
  output logic [7:0]        o_last_cmd,
  output logic [15:0]       o_rd_bytes
);

  // Only the low ADDR_W address bits matter; one bit fewer is kept because
  // the newest bit comes straight from the synchronized MOSI.
  localparam int SH_W = (ADDR_W - 1 > 7) ? ADDR_W - 1 : 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_ID     = 3'd4,
    S_STAT   = 3'd5,
`ifdef SPI_FLASH_FAST_READ_EN
    S_IGNORE = 3'd6,
    S_DUMMY  = 3'd7
`else
    S_IGNORE = 3'd6
`endif
  } state_t;

  state_t            state;
  logic [7:0]        mem [MEM_BYTES];
  logic              sclk_s1, sclk_s2, sclk_s3;
  logic              cs_s1, cs_s2, cs_prev;
  logic              mosi_s1, mosi_s2;
  logic [4:0]        bit_cnt;
  logic [2:0]        dbit;
  logic [SH_W-1:0]   shift_in;
  logic [23:0]       out_sreg;
  logic [ADDR_W-1:0] ptr;

  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0]        cmd_byte, mem_rd;
  logic [ADDR_W-1:0] addr_bits;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_prev;
  assign cs_rise   = cs_s2 & ~cs_prev;
  assign cmd_byte  = {shift_in[6:0], mosi_s2};
  assign addr_bits = {shift_in[ADDR_W-2:0], mosi_s2};
  assign mem_rd    = mem[ptr];

  always_ff @(posedge clock) begin
    if (i_load_we) mem[i_load_addr] <= i_load_data;
  end

  // cs chain resets low so a frame already in progress at reset release
  // never produces a fall; it must rise and fall again to be served.
  always_ff @(posedge clock) begin
    if (reset) begin
      {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
      {cs_s1, cs_s2, cs_prev}     <= 3'b000;
      {mosi_s1, mosi_s2}          <= 2'b00;
    end else begin
      {sclk_s1, sclk_s2, sclk_s3} <= {i_sclk, sclk_s1, sclk_s2};
      {cs_s1, cs_s2, cs_prev}     <= {i_cs_n, cs_s1, cs_s2};
      {mosi_s1, mosi_s2}          <= {i_mosi, mosi_s1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      o_miso     <= 1'b0;
      o_busy     <= 1'b0;
      o_last_cmd <= 8'h00;
      o_rd_bytes <= 16'h0000;
      bit_cnt    <= 5'd0;
      dbit       <= 3'd0;
      shift_in   <= '0;
      out_sreg   <= 24'h0;
      ptr        <= '0;
    end else if (cs_rise) begin
      state   <= S_IDLE;
      o_miso  <= 1'b0;
      o_busy  <= 1'b0;
      bit_cnt <= 5'd0;
      dbit    <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state   <= S_CMD;
            o_busy  <= 1'b1;
            bit_cnt <= 5'd0;
            dbit    <= 3'd0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            shift_in <= {shift_in[SH_W-2:0], mosi_s2};
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt    <= 5'd0;
              o_last_cmd <= cmd_byte;
              case (cmd_byte)
                8'h03: state <= S_ADDR;
                8'h9F: begin
                  state    <= S_ID;
                  out_sreg <= JEDEC_ID;
                end
                8'h05: state <= S_STAT;
`ifdef SPI_FLASH_FAST_READ_EN
                8'h0B: state <= S_ADDR;
`endif
                default: state <= S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            shift_in <= {shift_in[SH_W-2:0], mosi_s2};
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= 5'd0;
              dbit    <= 3'd0;
              ptr     <= addr_bits;
`ifdef SPI_FLASH_FAST_READ_EN
              state   <= (o_last_cmd == 8'h0B) ? S_DUMMY : S_DATA;
`else
              state   <= S_DATA;
`endif
            end
          end
        end
`ifdef SPI_FLASH_FAST_READ_EN
        S_DUMMY: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0;
              state   <= S_DATA;
            end
          end
        end
`endif
        S_DATA: begin
          if (sclk_fall) begin
            dbit <= dbit + 3'd1;
            if (dbit == 3'd0) begin
              // Byte is captured at its bit-7 fall, so backdoor writes to it
              // after this point only show on the next fetch.
              o_miso   <= mem_rd[7];
              out_sreg <= {mem_rd[6:0], 17'h0};
            end else begin
              o_miso   <= out_sreg[23];
              out_sreg <= {out_sreg[22:0], 1'b0};
            end
            if (dbit == 3'd7) begin
              ptr <= ptr + ADDR_W'(1);
              if (o_rd_bytes != 16'hFFFF) o_rd_bytes <= o_rd_bytes + 16'd1;
            end
          end
        end
        S_ID: begin
          if (sclk_fall) begin
            o_miso   <= out_sreg[23];
            out_sreg <= {out_sreg[22:0], 1'b0};
          end
        end
        S_STAT, S_IGNORE: o_miso <= 1'b0;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_responder
// Description : Randomized self-checking bench for spi_flash_responder with a
//               frame-level reference model (flash array, byte counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;
  localparam int          MEM_BYTES = 4096;
  localparam int          ADDR_W    = 12;
  localparam logic [23:0] JEDEC     = 24'hEF4016;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, load_we = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [7:0]        load_data = 8'h00;
  logic              miso, busy;
  logic [7:0]        last_cmd;
  logic [15:0]       rd_bytes;

  spi_flash_responder #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .JEDEC_ID(JEDEC)) dut (
    .clock(clock), .reset(reset), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .i_load_we(load_we), .i_load_addr(load_addr),
    .i_load_data(load_data), .o_busy(busy), .o_last_cmd(last_cmd),
    .o_rd_bytes(rd_bytes));

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] mem_m [MEM_BYTES];
  int         rd_m     = 0;
  logic [7:0] last_m   = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit is_read_op(input logic [7:0] op);
    return (op == 8'h03) || (FAST && op == 8'h0B);
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [23:0] addr, input int k);
    logic [23:0] t;
    if (is_read_op(op)) return mem_m[(int'(addr[ADDR_W-1:0]) + k) % MEM_BYTES];
    if (op == 8'h9F && k < 3) begin
      t = JEDEC >> (8 * (2 - k));
      return t[7:0];
    end
    return 8'h00;
  endfunction

  task automatic load(input int a, input logic [7:0] d);
    @(negedge clock);
    load_we = 1'b1; load_addr = ADDR_W'(a); load_data = d;
    mem_m[a] = d;
    @(negedge clock);
    load_we = 1'b0;
  endtask

  // One SCLK period, 12 system clocks; MISO sampled at the pin rise.
  task automatic sclk_bit(input logic b, output logic r);
    @(negedge clock);
    mosi = b;
    repeat (5) @(negedge clock);
    sclk = 1'b1;
    r = miso;
    repeat (6) @(negedge clock);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      sclk_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_begin();
    @(negedge clock);
    cs_n = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clock);
    cs_n = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic frame(input logic [7:0] op, input logic [23:0] addr, input int dclk);
    logic [7:0] rx, got;
    logic       bits [64];
    logic       r;
    cs_begin();
    xfer(op, rx);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    if (op == 8'h03 || op == 8'h0B) begin
      xfer(addr[23:16], rx); xfer(addr[15:8], rx); xfer(addr[7:0], rx);
      if (op == 8'h0B) xfer(8'($urandom), rx);
    end
    for (int i = 0; i < dclk; i++) begin
      sclk_bit(1'($urandom), r);
      bits[i] = r;
    end
    cs_end();
    for (int k = 0; k < dclk / 8; k++) begin
      for (int j = 0; j < 8; j++) got[7-j] = bits[8*k+j];
      check($sformatf("data op%0h a%0h k%0d", op, addr, k), {24'd0, got}, {24'd0, exp_byte(op, addr, k)});
    end
    // The bit-7 fall of the first byte precedes the first data clock.
    if (is_read_op(op)) rd_m += (dclk + 1) / 8;
    last_m = op;
    check("last_cmd", {24'd0, last_cmd}, {24'd0, last_m});
    check("rd_bytes", {16'd0, rd_bytes}, rd_m);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("miso_idle", {31'd0, miso}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rx, ops [6];
    logic [7:0]  op;
    logic        r;
    logic [23:0] a;
    ops[0] = 8'h03; ops[1] = 8'h03; ops[2] = 8'h9F;
    ops[3] = 8'h05; ops[4] = 8'h0B; ops[5] = 8'h00;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_last_cmd", {24'd0, last_cmd}, 32'd0);
    check("rst_rd_bytes", {16'd0, rd_bytes}, 32'd0);

    for (int i = 0; i < MEM_BYTES; i++) begin
      @(negedge clock);
      load_we = 1'b1; load_addr = ADDR_W'(i); load_data = 8'($urandom);
      mem_m[i] = load_data;
    end
    @(negedge clock);
    load_we = 1'b0;

    load(0, 8'hDE); load(1, 8'hAD); load(2, 8'hBE); load(3, 8'hEF);
    frame(8'h03, 24'h000000, 32);
    frame(8'h0B, 24'h000002, 8);
    frame(8'h03, 24'h000000, 12);
    frame(8'h03, 24'h000001, 8);
    frame(8'h9F, 24'h0, 24);
    frame(8'h05, 24'h0, 16);
    load(4095, 8'hA5); load(0, 8'h5A);
    frame(8'h03, 24'h000FFF, 16);
    frame(8'h03, 24'hABCFFE, 24);

    // Reset pulse in the middle of the address phase.
    cs_begin();
    xfer(8'h03, rx);
    xfer(8'h00, rx);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    rd_m = 0; last_m = 8'h00;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_miso", {31'd0, miso}, 32'd0);
    xfer(8'h00, rx); xfer(8'h00, rx);
    for (int i = 0; i < 16; i++) begin
      sclk_bit(1'($urandom), r);
      check("midrst_data", {31'd0, r}, 32'd0);
    end
    check("midrst_busy2", {31'd0, busy}, 32'd0);
    check("midrst_rd", {16'd0, rd_bytes}, 32'd0);
    check("midrst_last", {24'd0, last_cmd}, 32'd0);
    cs_end();
    frame(8'h03, 24'h000000, 32);

    for (int n = 0; n < 24; n++) begin
      op = ops[$urandom_range(0, 5)];
      if (op == 8'h00) op = 8'($urandom);
      a = 24'($urandom);
      frame(op, a, int'($urandom_range(1, 33)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
